uart_wb_master: RTL

Command sequencer that sits between the UART's AXI-stream byte ports and a 32-bit Wishbone bus, turning the serial link into a Wishbone bus master. It parses opcode/address/data frames from the UART RX stream and issues one classic Wishbone single read or write per frame. It returns a status byte, plus read data, on the UART TX stream. It replaces the loopback echo logic in the top level, wired directly to `uart` `m_axis_*` (RX) and `s_axis_*` (TX).

---
 rtl/uart_wb_pkg.sv | 14 +
 rtl/uart_wb_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/uart_wb_pkg.sv
// Opcodes, status codes and sequencer states shared by the UART-to-Wishbone bridge.
package uart_wb_pkg;

  localparam logic [7:0] OP_WRITE   = 8'hA1;
  localparam logic [7:0] OP_READ    = 8'hA2;

  localparam logic [7:0] ST_ACK     = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADOP   = 8'h03;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, STATUS, RDATA} state_t;

endpackage

// File: rtl/uart_wb_master.sv
// Turns opcode/address/data frames from the UART RX stream into single Wishbone
// cycles and answers with a status byte (plus read data) on the UART TX stream.
//   state  | meaning
//   IDLE   | waiting for an opcode byte
//   ADDR   | shifting in 4 address bytes, MSB first
//   DATA   | shifting in 4 write-data bytes, MSB first
//   BUS    | Wishbone cycle open, waiting for ack/err/timeout
//   STATUS | presenting the status byte
//   RDATA  | presenting 4 read-data bytes, MSB first
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [7:0]  status_q, status_nxt;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic        is_write, rdy_q;
  logic        rx_fire, tx_fire, tmo_hit;

  assign rx_fire = rx_tvalid & rdy_q;
  assign tx_fire = tx_tvalid & tx_tready;
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    case (state)
      IDLE: if (rx_fire) begin
        if (rx_tdata == OP_WRITE || rx_tdata == OP_READ) begin
          state_nxt = ADDR;
        end else begin
          status_nxt = ST_BADOP;
          state_nxt  = STATUS;
        end
      end
      ADDR:  if (rx_fire && byte_cnt == 2'd3) state_nxt = is_write ? DATA : BUS;
      DATA:  if (rx_fire && byte_cnt == 2'd3) state_nxt = BUS;
      BUS: begin
        // err beats ack, and ack beats a timeout landing on the same cycle
        if (wb_err_i) begin
          status_nxt = ST_ERR;
          state_nxt  = STATUS;
        end else if (wb_ack_i) begin
          status_nxt = ST_ACK;
          state_nxt  = STATUS;
        end else if (tmo_hit) begin
          status_nxt = ST_TIMEOUT;
          state_nxt  = STATUS;
        end
      end
      STATUS: if (tx_fire) state_nxt = (!is_write && status_q == ST_ACK) ? RDATA : IDLE;
      RDATA:  if (tx_fire && byte_cnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      status_q <= 8'h00;
      is_write <= 1'b0;
      byte_cnt <= 2'd0;
      tmo_cnt  <= 16'd0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      // registered so rx_tready stays low while reset is held
      rdy_q    <= (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == DATA);
      status_q <= status_nxt;
      if (state == IDLE && rx_fire) is_write <= (rx_tdata == OP_WRITE);
      if (state == IDLE) begin
        byte_cnt <= 2'd0;
      end else if (((state == ADDR || state == DATA) && rx_fire) || (state == RDATA && tx_fire)) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == ADDR && rx_fire) adr_q <= {adr_q[23:0], rx_tdata};
      if (state == DATA && rx_fire) dat_q <= {dat_q[23:0], rx_tdata};
      tmo_cnt <= (state == BUS) ? tmo_cnt + 16'd1 : 16'd0;
      if (state == BUS && !wb_err_i && wb_ack_i && !is_write) rdata_q <= wb_dat_i;
      else if (state == RDATA && tx_fire)                      rdata_q <= {rdata_q[23:0], 8'h00};
    end
  end

  assign rx_tready = rdy_q;
  assign tx_tvalid = (state == STATUS) || (state == RDATA);
  assign tx_tdata  = (state == STATUS) ? status_q :
                     (state == RDATA)  ? rdata_q[31:24] : 8'h00;
  assign wb_cyc_o  = (state == BUS);
  assign wb_stb_o  = (state == BUS);
  assign wb_we_o   = (state == BUS) && is_write;
  assign wb_sel_o  = (state == BUS) ? 4'hF : 4'h0;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign busy      = (state != IDLE);

endmodule
